// File: rtl/cbus_arbiter.sv
// cbus arbiter: shares one memory-side cbus between NUM_REQ cache controllers.
// Round-robin by default; define CBUS_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_REQ],
  output cbus_resp_t       iresps [NUM_REQ],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] w_grant_nxt;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_winner;
  logic             w_found;
  logic             w_done;
`ifndef CBUS_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_rr_nxt;
`endif

  function automatic logic [IDX_W-1:0] wrap_add(
    input logic [IDX_W-1:0] v,
    input int               k
  );
    int s;
    s = int'(v) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

`ifdef CBUS_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  assign w_start = r_rr_ptr;
`endif

  // first valid requester at or after the scan start, wrapping
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = wrap_add(w_start, k);
      if (!w_found && ireqs[w_idx].valid) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_done = !ireqs[r_grant].valid
                | (oresp.ready & oresp.last);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
`ifndef CBUS_ARB_FIXED_PRIO_EN
    w_rr_nxt    = r_rr_ptr;
`endif
    oreq        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      iresps[i] = '0;
    end
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_BUSY;
          w_grant_nxt = w_winner;
        end
      end
      S_BUSY: begin
        oreq            = ireqs[r_grant];
        iresps[r_grant] = oresp;
        if (w_done) begin
          w_state_nxt = S_IDLE;
`ifndef CBUS_ARB_FIXED_PRIO_EN
          w_rr_nxt    = wrap_add(r_grant, 1);
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
`ifndef CBUS_ARB_FIXED_PRIO_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
`ifndef CBUS_ARB_FIXED_PRIO_EN
      r_rr_ptr <= w_rr_nxt;
`endif
    end
  end

  assign busy      = (r_state == S_BUSY);
  assign grant_idx = r_grant;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: directed vector table plus randomized traffic
// checked against a queue-free behavioural ownership model.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 2;
  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h8000_0040;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       busy;
  logic [0:0] grant_idx;

  int checks   = 0;
  int failures = 0;

  bit m_busy = 1'b0;
  int m_own  = 0;
  int m_ptr  = 0;

  typedef struct {
    bit          rst;
    bit          v0;
    bit          v1;
    bit          rdy;
    bit          lst;
    bit          e_busy;
    int          e_gnt;
    bit          e_ov;
    logic [31:0] e_addr;
    bit          e_r0;
    bit          e_r1;
  } vec_t;

  vec_t tv[$];

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input bit rst, v0, v1, rdy, lst, eb,
                     input int eg, input bit eov,
                     input logic [31:0] ea, input bit er0, er1);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1; v.rdy = rdy; v.lst = lst;
    v.e_busy = eb; v.e_gnt = eg; v.e_ov = eov; v.e_addr = ea;
    v.e_r0 = er0; v.e_r1 = er1;
    tv.push_back(v);
  endtask

  task automatic set_fixed(input bit rst, v0, v1, rdy, lst, input int k);
    reset = rst;
    ireqs[0] = '{valid: v0, is_write: 1'b1, size: 3'd3, addr: A0,
                 strobe: 8'hff, data: 64'hA0A0_0000_0000_0000 + 64'(k),
                 len: 8'd3};
    ireqs[1] = '{valid: v1, is_write: 1'b0, size: 3'd3, addr: A1,
                 strobe: 8'h00, data: 64'h0, len: 8'd3};
    oresp = '{ready: rdy, last: lst,
              data: 64'hD00D_0000_0000_0000 + 64'(k)};
  endtask

  // Called mid-cycle: compare against model, then advance model over the edge.
  task automatic step();
    cbus_req_t  er;
    cbus_resp_t ep;
    chk("busy", 128'(busy), 128'(m_busy));
    chk("grant_idx", 128'(grant_idx), 128'(m_own));
    er = m_busy ? ireqs[m_own] : '0;
    chk("oreq", 128'(oreq), 128'(er));
    for (int i = 0; i < N; i++) begin
      ep = (m_busy && i == m_own) ? oresp : '0;
      chk($sformatf("iresps%0d", i), 128'(iresps[i]), 128'(ep));
    end
    @(posedge clk);
    if (reset) begin
      m_busy = 1'b0; m_own = 0; m_ptr = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && ireqs[(m_ptr + k) % N].valid) begin
          m_busy = 1'b1;
          m_own  = (m_ptr + k) % N;
        end
      end
    end else if (!ireqs[m_own].valid || (oresp.ready && oresp.last)) begin
      m_busy = 1'b0;
`ifndef CBUS_ARB_FIXED_PRIO_EN
      m_ptr  = (m_own + 1) % N;
`endif
    end
    #1;
  endtask

  initial begin
    set_fixed(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    // reset held, then idle
    add(1,0,0,0,0, 0,0,0,0,0,0);
    add(1,0,0,0,0, 0,0,0,0,0,0);
    for (int i = 0; i < 5; i++) add(0,0,0,0,0, 0,0,0,0,0,0);
    // single requester 1, 4-beat burst
    add(0,0,1,0,0, 0,0,0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,1,1,0, 1,1,1,A1,0,1);
    add(0,0,1,1,1, 1,1,1,A1,0,1);
    add(0,0,0,0,0, 0,1,0,0,0,0);
    // pointer back at 0: requester 0 wins, burst locked despite req 1
    add(0,1,1,0,0, 0,1,0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,1,1,0, 1,0,1,A0,1,0);
    add(0,1,1,1,1, 1,0,1,A0,1,0);
    add(0,1,1,0,0, 0,0,0,0,0,0);
`ifdef CBUS_ARB_FIXED_PRIO_EN
    add(0,1,1,1,0, 1,0,1,A0,1,0);
    add(0,1,0,0,0, 1,0,1,A0,0,0);
    add(0,1,0,1,0, 1,0,1,A0,1,0);
    add(0,1,0,1,0, 1,0,1,A0,1,0);
`else
    // req 1 granted, then aborts by dropping valid
    add(0,1,1,1,0, 1,1,1,A1,0,1);
    add(0,1,0,0,0, 1,1,0,A1,0,0);
    add(0,1,0,0,0, 0,1,0,0,0,0);
    add(0,1,0,1,0, 1,0,1,A0,1,0);
`endif
    // reset mid-burst
    add(1,1,1,0,0, 1,0,1,A0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);

    foreach (tv[k]) begin
      set_fixed(tv[k].rst, tv[k].v0, tv[k].v1, tv[k].rdy, tv[k].lst, k);
      @(negedge clk);
      chk($sformatf("vec%0d.busy", k), 128'(busy), 128'(tv[k].e_busy));
      chk($sformatf("vec%0d.grant", k), 128'(grant_idx),
          128'(tv[k].e_gnt));
      chk($sformatf("vec%0d.ovalid", k), 128'(oreq.valid),
          128'(tv[k].e_ov));
      chk($sformatf("vec%0d.oaddr", k), 128'(oreq.addr),
          128'(tv[k].e_addr));
      chk($sformatf("vec%0d.r0", k), 128'(iresps[0].ready),
          128'(tv[k].e_r0));
      chk($sformatf("vec%0d.r1", k), 128'(iresps[1].ready),
          128'(tv[k].e_r1));
      step();
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        ireqs[i].valid    = ($urandom_range(0, 3) != 0);
        ireqs[i].is_write = 1'($urandom);
        ireqs[i].size     = 3'($urandom);
        ireqs[i].addr     = $urandom;
        ireqs[i].strobe   = 8'($urandom);
        ireqs[i].data     = {$urandom, $urandom};
        ireqs[i].len      = 8'($urandom_range(0, 7));
      end
      oresp.ready = ($urandom_range(0, 2) != 0);
      oresp.last  = ($urandom_range(0, 3) == 0);
      oresp.data  = {$urandom, $urandom};
      @(negedge clk);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
